mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the register-file memory's single write port and read port 1 between two requesters.
- Requester A is the CPU pipeline (MEM stage); requester B is the boot loader / debug port.
- A boot/run/freeze state machine sequences access. Grants use valid/ready handshakes with round-robin between A and B.
- Read responses are returned to the issuing requester after the memory's fixed read latency.

Parameters:
ADDR_W, 11, address width (matches memory w_adrs/r_adrs1)
DATA_W, 11, data width (matches memory data_in/data_out1)
RD_LAT, 1, memory read latency in cycles from r_en1 edge to valid data_out1; must be >= 1

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
boot_done  input  1  loader finished; level, sampled in BOOT only
freeze  input  1  stop issuing new grants (debug halt)
a_valid  input  1  A request valid
a_ready  output  1  A request accepted this cycle
a_we  input  1  A: 1=write, 0=read
a_adrs  input  ADDR_W  A address
a_wdata  input  DATA_W  A write data
a_rvalid  output  1  A read data valid (1-cycle pulse)
a_rdata  output  DATA_W  A read data
b_valid, b_ready, b_we, b_adrs, b_wdata, b_rvalid, b_rdata  same as A, for requester B
mem_w_en  output  1  to memory w_en
mem_w_adrs  output  ADDR_W  to memory w_adrs
mem_data_in  output  DATA_W  to memory data_in
mem_r_en1  output  1  to memory r_en1
mem_r_adrs1  output  ADDR_W  to memory r_adrs1
mem_data_out1  input  DATA_W  from memory data_out1
state  output  2  FSM state: 0=BOOT, 1=RUN, 2=FREEZE

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, resetn.
- Reset values:
  - state=BOOT; last_grant=B, so A wins the first RUN tie.
  - Tag pipe cleared.
  - All readies, rvalids and mem enables 0.
  - All address/data outputs 0.
- FSM:
  - BOOT: only B eligible; a_ready=0. Goes to RUN on the clock edge where boot_done=1.
  - RUN: A and B eligible. Goes to FREEZE when freeze=1; freeze has priority over boot_done, which is ignored outside BOOT.
  - FREEZE: no grants, both readies 0. Goes to RUN when freeze=0.
  - Encoding 3 is unused; it recovers to BOOT.
- Grant is combinational from the current state, valids and last_grant. x_ready may depend on x_valid; x_ready is 0 whenever x_valid is 0.
- Transfer occurs when x_valid && x_ready; at most one transfer per cycle.
- Round-robin arbitration:
  - Both valid in RUN: grant the requester not equal to last_grant.
  - Single valid: grant it.
  - last_grant updates only on a transfer.
- Memory drive, combinational from the granted request:
  - mem_w_en = xfer && we; mem_r_en1 = xfer && !we.
  - mem_w_adrs and mem_data_in carry the granted address/data only when mem_w_en; otherwise 0.
  - mem_r_adrs1 carries the granted address only when mem_r_en1; otherwise 0.
  - Write commits at the same clock edge in the memory; the write completes silently, with no response.
- Read response routing:
  - Tag pipe of RD_LAT stages, each holding {valid, id}. A read transfer enters {1, requester} at stage 0.
  - When the final stage is valid: x_rvalid=1 for exactly one cycle for the tagged requester, and x_rdata = mem_data_out1 that cycle.
  - x_rdata=0 whenever x_rvalid=0.
  - Responses return in issue order; back-to-back reads give back-to-back rvalids.
- In-flight reads always complete across BOOT->RUN, RUN->FREEZE and FREEZE->RUN transitions.
- No read-after-write bypass here. Same-address write then read returns whatever the memory returns.
- Reset mid-operation clears the tag pipe; outstanding reads produce no rvalid.
- A requester must hold valid and its fields stable until ready. A deasserted valid is simply not granted; no error is flagged.

Test Plan:
- Boot lockout:
  - After reset, a_valid=1 read adrs 0x045 and b_valid=1 write adrs 0x045 data 0x1A4.
  - Required: only b_ready=1; mem_w_en=1, mem_w_adrs=0x045, mem_data_in=0x1A4; state stays 0.
- Boot exit and readback:
  - boot_done=1 -> state=1 next cycle.
  - A reads 0x045 -> mem_r_en1=1, mem_r_adrs1=0x045.
  - RD_LAT cycles later a_rvalid=1 for one cycle, a_rdata=0x1A4, b_rvalid=0.
- Round robin:
  - In RUN, A and B both hold valid reads for 4 cycles.
  - Required grants A,B,A,B; rvalids alternate a,b,a,b with matching data.
- Freeze:
  - Issue A read, then assert freeze next cycle with A and B valid.
  - Required: state=2, both readies 0, the in-flight a_rvalid still arrives.
  - freeze=0 -> state=1 and grants resume.
- Reset mid-read:
  - A read issued, then resetn=0 before RD_LAT elapses.
  - Required: all outputs 0 immediately, no rvalid after release, state=0.
- Single requester streaming:
  - Only B valid for 5 writes in RUN.
  - Required: b_ready=1 every cycle, 5 mem_w_en pulses with correct addresses/data, last_grant=B.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the register-file memory's write port and read port 1.
// Requester A is the CPU MEM stage and requester B is the boot loader / debug port.
// A BOOT/RUN/FREEZE state machine gates which requesters are eligible.
// Round-robin picks between A and B when both are valid.
// A tag pipe routes each read response back to the requester that issued it.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 11,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              boot_done,
  input  logic              freeze,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_adrs,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_adrs,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_w_adrs,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_r_en1,
  output logic [ADDR_W-1:0] mem_r_adrs1,
  input  logic [DATA_W-1:0] mem_data_out1,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    StBoot   = 2'd0,
    StRun    = 2'd1,
    StFreeze = 2'd2
  } state_e;

  state_e state_q, state_d;
  // 1 = B was granted last, 0 = A was granted last
  logic last_grant_q, last_grant_d;
  // Tag pipe: per-stage valid and requester id (1 = B)
  logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [RD_LAT-1:0] tag_id_q, tag_id_d;

  logic              gnt_a, gnt_b;
  logic              xfer, xfer_we;
  logic [ADDR_W-1:0] xfer_adrs;
  logic [DATA_W-1:0] xfer_wdata;

  // Grant selection from the current state, valids and round-robin pointer
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    case (state_q)
      StBoot: gnt_b = b_valid;
      StRun: begin
        if (a_valid && b_valid) begin
          gnt_a = last_grant_q;
          gnt_b = !last_grant_q;
        end else begin
          gnt_a = a_valid;
          gnt_b = b_valid;
        end
      end
      default: ;
    endcase
  end

  assign a_ready    = gnt_a;
  assign b_ready    = gnt_b;
  assign xfer       = gnt_a || gnt_b;
  assign xfer_we    = gnt_b ? b_we    : a_we;
  assign xfer_adrs  = gnt_b ? b_adrs  : a_adrs;
  assign xfer_wdata = gnt_b ? b_wdata : a_wdata;

  // Memory port drive; address/data are zeroed when the matching enable is low
  always_comb begin
    mem_w_en    = xfer && xfer_we;
    mem_r_en1   = xfer && !xfer_we;
    mem_w_adrs  = mem_w_en  ? xfer_adrs  : '0;
    mem_data_in = mem_w_en  ? xfer_wdata : '0;
    mem_r_adrs1 = mem_r_en1 ? xfer_adrs  : '0;
  end

  // Next state, round-robin pointer and tag pipe advance
  always_comb begin
    state_d = state_q;
    case (state_q)
      StBoot:   state_d = boot_done ? StRun : StBoot;
      StRun:    state_d = freeze ? StFreeze : StRun;
      StFreeze: state_d = freeze ? StFreeze : StRun;
      default:  state_d = StBoot;
    endcase

    last_grant_d = xfer ? gnt_b : last_grant_q;

    tag_vld_d    = '0;
    tag_id_d     = '0;
    tag_vld_d[0] = mem_r_en1;
    tag_id_d[0]  = gnt_b;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
  end

  // State registers; reset leaves B as last grant so A wins the first RUN tie
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StBoot;
      last_grant_q <= 1'b1;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      tag_vld_q    <= tag_vld_d;
      tag_id_q     <= tag_id_d;
    end
  end

  // Response routing from the last tag stage
  always_comb begin
    a_rvalid = tag_vld_q[RD_LAT-1] && !tag_id_q[RD_LAT-1];
    b_rvalid = tag_vld_q[RD_LAT-1] &&  tag_id_q[RD_LAT-1];
    a_rdata  = a_rvalid ? mem_data_out1 : '0;
    b_rdata  = b_rvalid ? mem_data_out1 : '0;
  end

  assign state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory.
// Read responses are checked by a scoreboard for requester, data and arrival cycle.
module tb_mem_port_arbiter;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 11;
  localparam int unsigned RD_LAT = 1;

  logic              clk = 1'b0;
  logic              resetn, boot_done, freeze;
  logic              a_valid, a_ready, a_we, a_rvalid;
  logic [ADDR_W-1:0] a_adrs;
  logic [DATA_W-1:0] a_wdata, a_rdata;
  logic              b_valid, b_ready, b_we, b_rvalid;
  logic [ADDR_W-1:0] b_adrs;
  logic [DATA_W-1:0] b_wdata, b_rdata;
  logic              mem_w_en, mem_r_en1;
  logic [ADDR_W-1:0] mem_w_adrs, mem_r_adrs1;
  logic [DATA_W-1:0] mem_data_in, mem_data_out1;
  logic [1:0]        state;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .resetn(resetn), .boot_done(boot_done), .freeze(freeze),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_adrs(a_adrs),
    .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_adrs(b_adrs),
    .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_w_en(mem_w_en), .mem_w_adrs(mem_w_adrs), .mem_data_in(mem_data_in),
    .mem_r_en1(mem_r_en1), .mem_r_adrs1(mem_r_adrs1), .mem_data_out1(mem_data_out1),
    .state(state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memory: write at the edge, read data RD_LAT edges after r_en1
  logic [DATA_W-1:0] mem [0:2047];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    if (mem_w_en) mem[mem_w_adrs] <= mem_data_in;
    rd_pipe[0] <= mem[mem_r_adrs1];
    for (int i = 1; i < int'(RD_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_data_out1 = rd_pipe[RD_LAT-1];

  typedef struct {
    bit                id;
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;
  exp_t exp_q[$];

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic set_a(input logic v, input logic we, input logic [ADDR_W-1:0] adr,
                       input logic [DATA_W-1:0] wd);
    a_valid = v; a_we = we; a_adrs = adr; a_wdata = wd;
  endtask

  task automatic set_b(input logic v, input logic we, input logic [ADDR_W-1:0] adr,
                       input logic [DATA_W-1:0] wd);
    b_valid = v; b_we = we; b_adrs = adr; b_wdata = wd;
  endtask

  task automatic idle();
    set_a(1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0);
  endtask

  task automatic expect_rd(input bit id, input logic [DATA_W-1:0] d);
    exp_t e;
    e.id = id; e.data = d; e.due = cyc + int'(RD_LAT);
    exp_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard whenever a response is presented
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (a_rvalid || b_rvalid) begin
        chk("single_rvalid", 32'(a_rvalid && b_rvalid), 32'd0);
        if (exp_q.size() == 0) begin
          n_tot++;
          $display("FAIL unexpected_rvalid: got a=%0b b=%0b required none (cycle %0d)",
                   a_rvalid, b_rvalid, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id", 32'(b_rvalid), 32'(e.id));
          chk("rsp_data", 32'(b_rvalid ? b_rdata : a_rdata), 32'(e.data));
          chk("rsp_other_rdata", 32'(b_rvalid ? a_rdata : b_rdata), 32'd0);
          chk("rsp_cycle", 32'(cyc), 32'(e.due));
        end
      end else begin
        chk("idle_rdata", {21'd0, a_rdata | b_rdata}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  logic [ADDR_W-1:0] a_list [2];
  logic [ADDR_W-1:0] b_list [2];

  initial begin
    int ai, bi;
    logic [ADDR_W-1:0] adr;
    bit exp_a;
    a_list[0] = 11'h010; a_list[1] = 11'h012;
    b_list[0] = 11'h011; b_list[1] = 11'h013;
    resetn = 1'b0; boot_done = 1'b0; freeze = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ready", 32'({a_ready, b_ready}), 32'd0);
    chk("rst_mem_en", 32'({mem_w_en, mem_r_en1}), 32'd0);
    chk("rst_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
    chk("rst_adrs", 32'(mem_w_adrs | mem_r_adrs1), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Boot lockout: only B is served
    set_a(1'b1, 1'b0, 11'h045, '0);
    set_b(1'b1, 1'b1, 11'h045, 11'h1A4);
    #1;
    chk("boot_a_ready", 32'(a_ready), 32'd0);
    chk("boot_b_ready", 32'(b_ready), 32'd1);
    chk("boot_w_en", 32'(mem_w_en), 32'd1);
    chk("boot_w_adrs", 32'(mem_w_adrs), 32'h045);
    chk("boot_data_in", 32'(mem_data_in), 32'h1A4);
    chk("boot_r_en", 32'(mem_r_en1), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_b(1'b1, 1'b1, 11'(11'h010 + i), 11'(11'h300 + 5 * i));
      #1;
      chk("boot_fill_a_ready", 32'(a_ready), 32'd0);
      chk("boot_fill_w_adrs", 32'(mem_w_adrs), 32'(11'h010 + i));
      chk("boot_state", 32'(state), 32'd0);
    end

    // Boot exit and readback
    @(negedge clk);
    idle(); boot_done = 1'b1;
    #1 chk("boot_hold_state", 32'(state), 32'd0);
    @(negedge clk);
    boot_done = 1'b0;
    #1 chk("run_state", 32'(state), 32'd1);
    @(negedge clk);
    set_a(1'b1, 1'b0, 11'h045, '0);
    #1;
    chk("rd_a_ready", 32'(a_ready), 32'd1);
    chk("rd_r_en", 32'(mem_r_en1), 32'd1);
    chk("rd_r_adrs", 32'(mem_r_adrs1), 32'h045);
    chk("rd_w_en", 32'(mem_w_en), 32'd0);
    expect_rd(1'b0, 11'h1A4);
    @(negedge clk);
    set_a(1'b0, 1'b0, '0, '0);
    set_b(1'b1, 1'b1, 11'h020, 11'h055);
    #1 chk("run_b_write", 32'(b_ready), 32'd1);

    // Round robin: B went last, so expect A,B,A,B
    ai = 0; bi = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      set_a(1'b1, 1'b0, a_list[ai], '0);
      set_b(1'b1, 1'b0, b_list[bi], '0);
      #1;
      exp_a = (k % 2) == 0;
      adr = exp_a ? a_list[ai] : b_list[bi];
      chk("rr_a_ready", 32'(a_ready), 32'(exp_a));
      chk("rr_b_ready", 32'(b_ready), 32'(!exp_a));
      chk("rr_r_adrs", 32'(mem_r_adrs1), 32'(adr));
      expect_rd(!exp_a, 11'(11'h300 + 5 * (adr - 11'h010)));
      if (exp_a) ai++;
      else bi++;
    end

    // Freeze with an in-flight read
    @(negedge clk);
    idle();
    set_a(1'b1, 1'b0, 11'h045, '0);
    freeze = 1'b1;
    #1 chk("frz_issue_a_ready", 32'(a_ready), 32'd1);
    expect_rd(1'b0, 11'h1A4);
    @(negedge clk);
    set_a(1'b1, 1'b0, 11'h010, '0);
    set_b(1'b1, 1'b0, 11'h011, '0);
    #1;
    chk("frz_state", 32'(state), 32'd2);
    chk("frz_ready", 32'({a_ready, b_ready}), 32'd0);
    chk("frz_mem_en", 32'({mem_w_en, mem_r_en1}), 32'd0);
    @(negedge clk);
    freeze = 1'b0;
    #1 chk("frz_exit_state", 32'(state), 32'd2);
    chk("frz_exit_ready", 32'({a_ready, b_ready}), 32'd0);
    @(negedge clk);
    #1;
    chk("unfrz_state", 32'(state), 32'd1);
    chk("unfrz_b_ready", 32'(b_ready), 32'd1);
    chk("unfrz_a_ready", 32'(a_ready), 32'd0);
    expect_rd(1'b1, 11'h305);
    @(negedge clk);
    set_b(1'b0, 1'b0, '0, '0);
    #1 chk("unfrz_a_next", 32'(a_ready), 32'd1);
    expect_rd(1'b0, 11'h300);
    @(negedge clk);
    idle();

    // Reset with a read outstanding: its response must never appear
    @(negedge clk);
    set_a(1'b1, 1'b0, 11'h012, '0);
    #1 chk("mid_a_ready", 32'(a_ready), 32'd1);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    idle();
    #1;
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
    chk("mid_rst_rdata", 32'(a_rdata | b_rdata), 32'd0);
    chk("mid_rst_mem", 32'({mem_w_en, mem_r_en1, mem_w_adrs, mem_r_adrs1, mem_data_in}), 32'd0);
    chk("mid_rst_ready", 32'({a_ready, b_ready}), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk("post_rst_state", 32'(state), 32'd0);

    // Single requester streaming writes in RUN
    @(negedge clk);
    boot_done = 1'b1;
    @(negedge clk);
    boot_done = 1'b0;
    #1 chk("run2_state", 32'(state), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      set_b(1'b1, 1'b1, 11'(11'h030 + i), 11'(11'h100 + i));
      #1;
      chk("strm_b_ready", 32'(b_ready), 32'd1);
      chk("strm_w_en", 32'(mem_w_en), 32'd1);
      chk("strm_w_adrs", 32'(mem_w_adrs), 32'(11'h030 + i));
      chk("strm_data_in", 32'(mem_data_in), 32'(11'h100 + i));
    end
    // B went last, so a tie goes to A
    @(negedge clk);
    set_a(1'b1, 1'b0, 11'h030, '0);
    set_b(1'b1, 1'b0, 11'h031, '0);
    #1;
    chk("strm_tie_a", 32'(a_ready), 32'd1);
    chk("strm_tie_b", 32'(b_ready), 32'd0);
    expect_rd(1'b0, 11'h100);
    @(negedge clk);
    idle();
    repeat (RD_LAT + 3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
